fifo_rr_arbiter: RTL
====================

Name: fifo_rr_arbiter

Overview:
- Router output-stage arbiter that sits directly downstream of NUM_INPUTS input fifo instances.
- Watches each fifo's empty flag and head item, then pops exactly one non-empty fifo per grant using a round-robin policy.
- Registers the popped item into a single-entry output stage that drives the outgoing link with a valid/ready handshake.
- Single-flit items only; there is no packet locking.

Parameters:
- ID, -1: instance identifier, used only in $display trace messages.
- SIZE, 8: item width in bits; identical to the upstream fifo SIZE.
- DESTINATION_BITS, 4: width of the destination field, item[DESTINATION_BITS-1:0].
- NUM_INPUTS, 4: number of upstream fifos; legal range 2..16.
- PORT_BITS, 2: width of the input index; 2**PORT_BITS >= NUM_INPUTS is required.
- COUNT_BITS, 16: width of the forwarded-item counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- empty  input  NUM_INPUTS  empty flag of each upstream fifo
- items_in  input  NUM_INPUTS*SIZE  head item of each fifo; input i is at [i*SIZE +: SIZE]
- read  output  NUM_INPUTS  pop strobe to each fifo; combinational, at most one bit high
- out_item  output  SIZE  registered item presented to the link
- out_valid  output  1  out_item holds a valid item
- out_ready  input  1  downstream accepts out_item this cycle
- out_port  output  PORT_BITS  index of the input that out_item came from
- fwd_count  output  COUNT_BITS  number of items that completed the output handshake; wraps

Behaviour:
- Reset (synchronous, active-high):
  - At the next clk edge: out_valid=0, out_item=0, out_port=0, rr_ptr=0, fwd_count=0.
  - read is forced to 0 while reset is high, so no fifo is popped during reset.
  - Reset during a pending output item discards that item without popping anything further.
- Load condition: load = !out_valid | (out_valid & out_ready). This gives back-to-back throughput of 1 item per cycle.
- Grant selection (combinational):
  - Search from rr_ptr upward, modulo NUM_INPUTS, for the first i with empty[i]==0.
  - If one is found, g = i and grant_valid=1; otherwise grant_valid=0.
- Pop: read[g] = load & grant_valid & !reset; all other read bits are 0.
  - The fifo's head item is combinational, so items_in[g] is valid in the same cycle and the fifo advances at the same edge.
- On a grant edge: out_item <= items_in[g], out_valid <= 1, out_port <= g, rr_ptr <= (g+1) mod NUM_INPUTS.
- On a load edge with no grant: out_valid <= 0; out_item, out_port and rr_ptr hold.
- Stall: while out_valid & !out_ready, out_item, out_port and rr_ptr hold, and all read bits are 0.
- fwd_count increments by 1 on every edge where out_valid & out_ready. It wraps from 2**COUNT_BITS-1 to 0.
- rr_ptr wrap: after a grant to input NUM_INPUTS-1, rr_ptr becomes 0. rr_ptr never holds a value >= NUM_INPUTS.
- Fairness: while any input stays continuously non-empty, it is granted within NUM_INPUTS grants.
- Illegal-usage checks ($display error under simulation):
  - more than one read bit high in the same cycle;
  - read[i] high while empty[i] is high.
- Trace: $display per grant in the fifo's format: time, "ARBITER", ID, payload:destination, and the granted port.

Decomposition:
- Shared include-guarded header (`ifndef style), reused by fifo and the router top:
  - item field macros: destination slice [DESTINATION_BITS-1:0], payload slice [SIZE-1:DESTINATION_BITS];
  - default SIZE and DESTINATION_BITS constants.
- One natural sub-module, rr_select:
  - purely combinational;
  - inputs: request vector (~empty) and rr_ptr;
  - outputs: grant index g and grant_valid;
  - parameterised by NUM_INPUTS and PORT_BITS.
- The output register, rr_ptr, counter and read gating stay in fifo_rr_arbiter.

Test Plan:
1. Reset with all inputs non-empty and reset held 3 cycles:
   - read==0 throughout, out_valid==0, fwd_count==0.
   - First grant comes one cycle after reset deasserts: port 0.
2. NUM_INPUTS=4, all non-empty, out_ready=1 constantly:
   - grants run 0,1,2,3,0,1 on consecutive cycles;
   - out_valid stays 1 throughout;
   - fwd_count reaches 6 after 6 handshakes.
3. Only input 2 non-empty, holding items 8'h51, 8'h63; out_ready=1:
   - out_item is 8'h51 then 8'h63, with out_port=2 both times;
   - then out_valid drops to 0;
   - read[2] pulses exactly twice.
4. Backpressure:
   - out_ready=0 for 5 cycles with out_valid=1: out_item stable and read==0 for all 5 cycles.
   - Then raise out_ready: pop and handshake happen on the same edge, with no bubble.
5. rr_ptr=3 after a grant to input 2, inputs 1 and 3 non-empty:
   - next grant is 3, then 1;
   - input 0 becoming non-empty after that is granted before input 1 is granted again.
6. Counter wrap with COUNT_BITS=4: after 16 handshakes, fwd_count==0. Then assert reset mid-stream with out_valid=1: out_valid==0 next cycle and no read pulse occurs.

Source files
------------

// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared definitions for the fifo round-robin arbiter slice.
//   - Item field macros (include-guarded so fifo and router files can
//     share them): destination = low DESTINATION_BITS, payload = the rest.
//   - Default item geometry, identical to the upstream fifo defaults.
//   - wrap_next(): index + 1 modulo n, used for the round-robin pointer.
`ifndef FIFO_ITEM_DEFS_SV
`define FIFO_ITEM_DEFS_SV
`define FIFO_ITEM_DEST(it)    it[DESTINATION_BITS-1:0]
`define FIFO_ITEM_PAYLOAD(it) it[SIZE-1:DESTINATION_BITS]
`endif

package fifo_rr_arbiter_pkg;

   localparam int DEFAULT_SIZE             = 8;
   localparam int DEFAULT_DESTINATION_BITS = 4;

   function automatic int wrap_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// Handshake bundle between the upstream fifos, the arbiter and the link.
//   empty     : per-fifo empty flags
//   items_in  : per-fifo head items, input i at [i*SIZE +: SIZE]
//   read      : per-fifo pop strobes (from arbiter)
//   out_item  : registered item on the link
//   out_valid : out_item is valid
//   out_ready : link accepts out_item this cycle
//   out_port  : input index out_item came from
// master = arbiter side, slave = fifo/link environment side.
interface fifo_rr_arbiter_if
   import fifo_rr_arbiter_pkg::*;
#(
   parameter int SIZE       = DEFAULT_SIZE,
   parameter int NUM_INPUTS = 4,
   parameter int PORT_BITS  = 2
);
   logic [NUM_INPUTS-1:0]      empty;
   logic [NUM_INPUTS*SIZE-1:0] items_in;
   logic [NUM_INPUTS-1:0]      read;
   logic [SIZE-1:0]            out_item;
   logic                       out_valid;
   logic                       out_ready;
   logic [PORT_BITS-1:0]       out_port;

   modport master (
      input  empty, items_in, out_ready,
      output read, out_item, out_valid, out_port
   );

   modport slave (
      output empty, items_in, out_ready,
      input  read, out_item, out_valid, out_port
   );
endinterface

// File: rtl/fifo_rr_arbiter_rr_select.sv
// Combinational round-robin selector.
//   request     : one bit per input, high when that input wants a grant
//   rr_ptr      : highest-priority input index (must be < NUM_INPUTS)
//   grant_idx   : first requesting index at or after rr_ptr, modulo NUM_INPUTS
//   grant_valid : at least one request present
module fifo_rr_arbiter_rr_select #(
   parameter int NUM_INPUTS = 4,
   parameter int PORT_BITS  = 2
)(
   input  logic [NUM_INPUTS-1:0] request,
   input  logic [PORT_BITS-1:0]  rr_ptr,
   output logic [PORT_BITS-1:0]  grant_idx,
   output logic                  grant_valid
);
   logic [NUM_INPUTS-1:0] rotated;
   int                    sum;

   always_comb begin
      // Rotate so bit 0 is the input at rr_ptr; the first set bit is then
      // the offset of the winner relative to the pointer.
      rotated     = NUM_INPUTS'({request, request} >> rr_ptr);
      grant_idx   = '0;
      grant_valid = 1'b0;
      sum         = 0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         if (!grant_valid && rotated[k]) begin
            grant_valid = 1'b1;
            sum = int'(rr_ptr) + k;
            if (sum >= NUM_INPUTS) sum = sum - NUM_INPUTS;
            grant_idx = PORT_BITS'(sum);
         end
      end
   end
endmodule

// File: rtl/fifo_rr_arbiter.sv
// Router output-stage arbiter: pops one non-empty upstream fifo per grant
// (round-robin) into a single-entry output register with valid/ready.
//   clk       : rising-edge clock
//   reset     : synchronous active-high reset
//   bus       : fifo_rr_arbiter_if.master (fifo flags/heads, pops, link)
//   fwd_count : items that completed the output handshake, wrapping
module fifo_rr_arbiter
   import fifo_rr_arbiter_pkg::*;
#(
   parameter int ID               = -1,
   parameter int SIZE             = DEFAULT_SIZE,
   parameter int DESTINATION_BITS = DEFAULT_DESTINATION_BITS,
   parameter int NUM_INPUTS       = 4,
   parameter int PORT_BITS        = 2,
   parameter int COUNT_BITS       = 16
)(
   input  logic                  clk,
   input  logic                  reset,
   fifo_rr_arbiter_if.master     bus,
   output logic [COUNT_BITS-1:0] fwd_count
);
   logic [NUM_INPUTS-1:0] request;
   logic [PORT_BITS-1:0]  rr_ptr_reg;
   logic [PORT_BITS-1:0]  grant_idx;
   logic                  grant_valid;
   logic                  load;
   logic                  pop;
   logic [SIZE-1:0]       items [NUM_INPUTS];
   logic [SIZE-1:0]       head_item;
   logic [SIZE-1:0]       item_reg;
   logic                  valid_reg;
   logic [PORT_BITS-1:0]  port_reg;
   logic [COUNT_BITS-1:0] count_reg;

   assign request = ~bus.empty;

   fifo_rr_arbiter_rr_select #(
      .NUM_INPUTS (NUM_INPUTS),
      .PORT_BITS  (PORT_BITS)
   ) u_select (
      .request     (request),
      .rr_ptr      (rr_ptr_reg),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // Output stage can take a new item when empty or being drained now.
   assign load = !valid_reg || bus.out_ready;
   assign pop  = load && grant_valid && !reset;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_port
         assign items[gi]    = bus.items_in[gi*SIZE +: SIZE];
         assign bus.read[gi] = pop && (grant_idx == PORT_BITS'(gi));
      end
   endgenerate

   assign head_item = items[grant_idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         item_reg   <= '0;
         valid_reg  <= 1'b0;
         port_reg   <= '0;
         rr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (valid_reg && bus.out_ready) count_reg <= count_reg + 1'b1;
         if (load) begin
            if (grant_valid) begin
               item_reg   <= head_item;
               valid_reg  <= 1'b1;
               port_reg   <= grant_idx;
               rr_ptr_reg <= PORT_BITS'(wrap_next(int'(grant_idx), NUM_INPUTS));
            end else begin
               valid_reg  <= 1'b0;
            end
         end
      end
   end

   assign bus.out_item  = item_reg;
   assign bus.out_valid = valid_reg;
   assign bus.out_port  = port_reg;
   assign fwd_count     = count_reg;

`ifndef SYNTHESIS
   // Usage checks and grant trace in the fifo's message format.
   always @(posedge clk) begin
      if (!reset) begin
         if ($countones(bus.read) > 1)
            $display("%0t ARBITER %0d error: multiple read bits %b", $time, ID, bus.read);
         if ((bus.read & bus.empty) != '0)
            $display("%0t ARBITER %0d error: read of empty fifo %b", $time, ID, bus.read & bus.empty);
         if (pop)
            $display("%0t ARBITER %0d %h:%h port %0d", $time, ID,
                     `FIFO_ITEM_PAYLOAD(head_item), `FIFO_ITEM_DEST(head_item), grant_idx);
      end
   end
`endif
endmodule
